nn_vga_dot_display: RTL and testbench

Display-side consumer of the SoC's four VGA coordinate registers (red X/Y, green X/Y). It generates 640x480@60 VGA raster timing from the system clock and paints one red and one green square dot at the CPU-programmed coordinates. Coordinates are shadowed once per frame so the CPU can update them at any time without tearing. The block sits between the SoC's VGA_* output ports and the board's VGA DAC/connector.

---
 rtl/nn_vga_pkg.sv | 35 +++
 rtl/nn_vga_timing.sv | 76 +++++++
 rtl/nn_vga_dot_display.sv | 120 ++++++++++++
 tb/tb_nn_vga_dot_display.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/nn_vga_pkg.sv
// Shared timing defaults, counter widths and colour constants for the VGA dot display.
package nn_vga_pkg;
    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_DOT_SIZE = 8;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int CNT_W = 10;
    localparam int SHD_W = 11;
    localparam int SUM_W = 12;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t BLACK  = 12'h000;
    localparam rgb_t RED    = 12'hF00;
    localparam rgb_t GREEN  = 12'h0F0;
    localparam rgb_t YELLOW = 12'hFF0;

    // Anything that does not fit in 11 bits parks the dot at 0x7FF, far off-screen.
    function automatic logic [SHD_W-1:0] sat_coord(input logic [31:0] coord);
        return (|coord[31:SHD_W]) ? {SHD_W{1'b1}} : coord[SHD_W-1:0];
    endfunction
endpackage

// File: rtl/nn_vga_timing.sv
// Pixel divider, horizontal/vertical raster counters and sync decode.
module nn_vga_timing
    import nn_vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hsync,
    output logic             vsync,
    output logic             vblank_start,
    output logic             frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_BEGIN   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEGIN   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic             h_last;
    logic             v_last;

    assign tick   = (div == DIV_LAST);
    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hsync  = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
    assign vsync  = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);

    // Position flag: the next tick moves the raster into the first blanking line.
    assign vblank_start = h_last && (v_cnt == V_ACT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            div         <= tick ? '0 : div + 1'b1;
            // Only a real wrap marks a frame; leaving reset at (0,0) does not.
            frame_start <= tick && h_last && v_last;
            if (tick) begin
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/nn_vga_dot_display.sv
// 640x480 VGA raster painting a red and a green square dot at frame-shadowed CPU coordinates.
module nn_vga_dot_display
    import nn_vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int DOT_SIZE = DEF_DOT_SIZE,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] VGA_X_R,
    input  logic [31:0] VGA_Y_R,
    input  logic [31:0] VGA_X_G,
    input  logic [31:0] VGA_Y_G,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        FRAME_START
);
    localparam logic [SUM_W-1:0] DOT_EXT = SUM_W'(DOT_SIZE);

    logic             tick;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             active;
    logic             hsync;
    logic             vsync;
    logic             vblank_start;
    logic             frame_start;

    logic [SHD_W-1:0] x_r, y_r, x_g, y_g;
    logic             hit_r, hit_g;
    rgb_t             rgb_next, rgb_q;

    nn_vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk          (CLK),
        .rst          (RST),
        .tick         (tick),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .active       (active),
        .hsync        (hsync),
        .vsync        (vsync),
        .vblank_start (vblank_start),
        .frame_start  (frame_start)
    );

    // 12-bit compare so a dot near 0x7FF cannot wrap back onto the screen.
    function automatic logic on_dot(input logic [SHD_W-1:0] origin, input logic [CNT_W-1:0] pos);
        logic [SUM_W-1:0] o;
        logic [SUM_W-1:0] p;
        o = SUM_W'(origin);
        p = SUM_W'(pos);
        return (p >= o) && (p < o + DOT_EXT);
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            x_r <= '0;
            y_r <= '0;
            x_g <= '0;
            y_g <= '0;
        end else if (tick && vblank_start) begin
            x_r <= sat_coord(VGA_X_R);
            y_r <= sat_coord(VGA_Y_R);
            x_g <= sat_coord(VGA_X_G);
            y_g <= sat_coord(VGA_Y_G);
        end
    end

    assign hit_r = active && on_dot(x_r, h_cnt) && on_dot(y_r, v_cnt);
    assign hit_g = active && on_dot(x_g, h_cnt) && on_dot(y_g, v_cnt);

    always_comb begin
        rgb_next = BLACK;
        case ({hit_r, hit_g})
            2'b11:   rgb_next = YELLOW;
            2'b10:   rgb_next = RED;
            2'b01:   rgb_next = GREEN;
            default: rgb_next = BLACK;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            rgb_q       <= BLACK;
            FRAME_START <= 1'b0;
        end else begin
            VGA_HS      <= ~hsync;
            VGA_VS      <= ~vsync;
            rgb_q       <= rgb_next;
            FRAME_START <= frame_start;
        end
    end

    assign VGA_R = rgb_q.r;
    assign VGA_G = rgb_q.g;
    assign VGA_B = rgb_q.b;
endmodule

// File: tb/tb_nn_vga_dot_display.sv
// Cycle-accurate check of a shrunken raster against an arithmetic pixel/frame model.
module tb_nn_vga_dot_display;
    localparam int CLK_DIV = 2;
    localparam int DOT     = 4;
    localparam int HA = 32, HFP = 4, HSY = 6, HBP = 6;
    localparam int VA = 24, VFP = 2, VSY = 2, VBP = 3;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME_CLKS = HT * VT * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] xr = '0, yr = '0, xg = '0, yg = '0;
    logic        hs, vs, fs;
    logic [3:0]  r, g, b;

    int checks = 0;
    int failures = 0;
    int t = 0;
    int sxr = 0, syr = 0, sxg = 0, syg = 0;
    int fs_seen = 0;

    always #5 clk = ~clk;

    nn_vga_dot_display #(
        .CLK_DIV (CLK_DIV), .DOT_SIZE (DOT),
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP)
    ) dut (
        .CLK (clk), .RST (rst),
        .VGA_X_R (xr), .VGA_Y_R (yr), .VGA_X_G (xg), .VGA_Y_G (yg),
        .VGA_HS (hs), .VGA_VS (vs),
        .VGA_R (r), .VGA_G (g), .VGA_B (b),
        .FRAME_START (fs)
    );

    function automatic int sat(input logic [31:0] c);
        return (c > 32'd2047) ? 2047 : int'(c);
    endfunction

    function automatic bit hit(input int x, input int y, input int h, input int v);
        return (h < HA) && (v < VA) && (h >= x) && (h < x + DOT) && (v >= y) && (v < y + DOT);
    endfunction

    function automatic logic [31:0] rnd_coord(input int lim);
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 32'h0000_1000;
        if (sel == 1) return 32'h0000_0800 | 32'($urandom);
        if (sel == 2) return 32'h0000_07FF;
        return 32'($urandom_range(0, lim + DOT));
    endfunction

    // Outputs after edge t describe the raster position reached after t-1 edges.
    task automatic step();
        bit         e_hs, e_vs, e_fs;
        logic [11:0] e_rgb;
        int         k, p, h, v;
        @(posedge clk);
        #1;
        if (rst) begin
            t = 0;
            sxr = 0; syr = 0; sxg = 0; syg = 0;
            e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_rgb = 12'h000;
        end else begin
            t++;
            k = t - 1;
            p = k / CLK_DIV;
            h = p % HT;
            v = (p / HT) % VT;
            e_hs  = !((h >= HA + HFP) && (h < HA + HFP + HSY));
            e_vs  = !((v >= VA + VFP) && (v < VA + VFP + VSY));
            e_fs  = (p > 0) && (k % CLK_DIV == 0) && (p % (HT * VT) == 0);
            e_rgb = {hit(sxr, syr, h, v) ? 4'hF : 4'h0, hit(sxg, syg, h, v) ? 4'hF : 4'h0, 4'h0};
        end
        checks++;
        assert (hs === e_hs) else begin
            failures++; $error("FAIL hs t=%0d got=%b exp=%b", t, hs, e_hs);
        end
        checks++;
        assert (vs === e_vs) else begin
            failures++; $error("FAIL vs t=%0d got=%b exp=%b", t, vs, e_vs);
        end
        checks++;
        assert ({r, g, b} === e_rgb) else begin
            failures++; $error("FAIL rgb t=%0d got=%h exp=%h", t, {r, g, b}, e_rgb);
        end
        checks++;
        assert (fs === e_fs) else begin
            failures++; $error("FAIL frame_start t=%0d got=%b exp=%b", t, fs, e_fs);
        end
        if (fs === 1'b1) fs_seen++;
        // Coordinates latch on the edge that enters the first blanking line.
        if (!rst && (t % CLK_DIV == 0) && ((t / CLK_DIV) % HT == 0)
                 && (((t / CLK_DIV) / HT) % VT == VA)) begin
            sxr = sat(xr); syr = sat(yr); sxg = sat(xg); syg = sat(yg);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int line, input int pix);
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            step();
            if ((t % CLK_DIV == 0) && ((t / CLK_DIV) % HT == pix)
                && (((t / CLK_DIV) / HT) % VT == line)) break;
        end
    endtask

    initial begin
        // reset held three cycles
        rst = 1'b1;
        run(3);
        rst = 1'b0;

        // red visible, green beyond the right edge; first frame shows yellow at (0,0)
        xr = 10; yr = 5; xg = 40; yg = 5;
        run(2 * FRAME_CLKS);

        // overlap: red 10..13, green 12..15 -> yellow on 12..13
        xr = 10; yr = 10; xg = 12; yg = 10;
        run(FRAME_CLKS);

        // clipped at bottom-right corner, green saturated
        xr = 30; yr = 22; xg = 32'h0000_1000; yg = 3;
        run(FRAME_CLKS);

        // tear-free: red X moves mid-frame, only visible next frame
        xr = 4; yr = 8; xg = 32'hFFFF_0000; yg = 0;
        run_to(VA + 1, 0);
        run_to(12, 0);
        xr = 20;
        run(FRAME_CLKS + FRAME_CLKS / 2);

        // randomized coordinate updates at arbitrary moments
        for (int i = 0; i < 5 * FRAME_CLKS; i++) begin
            step();
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 3))
                    0: xr = rnd_coord(HA);
                    1: yr = rnd_coord(VA);
                    2: xg = rnd_coord(HA);
                    default: yg = rnd_coord(VA);
                endcase
            end
        end

        // reset mid-frame; next frame marker a full frame after release
        xr = 6; yr = 6; xg = 7; yg = 7;
        run_to(20, 25);
        rst = 1'b1;
        step();
        rst = 1'b0;
        fs_seen = 0;
        run(FRAME_CLKS + 4);
        checks++;
        assert (fs_seen === 1) else begin
            failures++; $error("FAIL fs_count_after_reset got=%0d exp=1", fs_seen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
